// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter gate controller.
// Provides the controller state type, the range codes driven on
// Status_Value, and the lookup from range code to the last ms index
// of the gate window.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_SETTLE,
    ST_STORE,
    ST_EVAL,
    ST_HOLD
  } gate_state_t;

  localparam logic [1:0] RANGE_1S    = 2'd0;
  localparam logic [1:0] RANGE_100MS = 2'd1;
  localparam logic [1:0] RANGE_10MS  = 2'd2;
  localparam logic [1:0] RANGE_1MS   = 2'd3;

  // Last value of the decade ms counter for a gate of the given range.
  function automatic logic [9:0] ms_terminal(input logic [1:0] range);
    logic [9:0] term;
    case (range)
      RANGE_1S:    term = 10'd999;
      RANGE_100MS: term = 10'd99;
      RANGE_10MS:  term = 10'd9;
      default:     term = 10'd0;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Divides the reference clock down to a one-cycle tick every TICKS
// enabled cycles.
//   clk     : reference clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear of the divider
//   en      : count enable
//   ms_tick : high for the last enabled cycle of each TICKS period
module ms_prescaler #(
  parameter int unsigned TICKS = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic ms_tick
);

  localparam int unsigned     CW   = $clog2(TICKS);
  localparam logic [CW-1:0]   LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  assign ms_tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= ms_tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-time and auto-range controller for the frequency meter.
// Sequences each measurement as Clear pulse, timed En gate window,
// settle gap, Store pulse, then evaluates the latched result to pick
// the range of the next measurement.
//   CP, nRST     : reference clock / async active-low reset
//   Auto         : 1 = auto-range, 0 = use Man_Range
//   Man_Range    : manual range code
//   Overflow     : counter overflow, valid from Store until next Clear
//   BCD3         : latched most-significant result digit
//   Clear        : one-cycle counter clear
//   En           : gate window / count enable
//   Store        : one-cycle latch strobe
//   Status_Value : current range (0 = 1 s ... 3 = 1 ms gate)
//   Over_Ind     : out-of-range indication
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned TICKS_1MS  = 1000,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned HOLD_MS    = 500
) (
  input  logic       CP,
  input  logic       nRST,
  input  logic       Auto,
  input  logic [1:0] Man_Range,
  input  logic       Overflow,
  input  logic [3:0] BCD3,
  output logic       Clear,
  output logic       En,
  output logic       Store,
  output logic [1:0] Status_Value,
  output logic       Over_Ind
);

  localparam int unsigned   SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [9:0]    HOLD_TERM   = 10'(HOLD_MS - 1);

  gate_state_t   state;
  logic [9:0]    ms_cnt;
  logic [SW-1:0] settle_cnt;
  logic          ms_tick;
  logic [1:0]    next_range;
  logic          next_over;

  // The prescaler runs only while timing the gate or the hold; it sits
  // at zero through SETTLE/STORE/EVAL because the gate ends on a wrap.
  ms_prescaler #(
    .TICKS (TICKS_1MS)
  ) u_prescaler (
    .clk     (CP),
    .rst_n   (nRST),
    .clr     (state == ST_CLEAR),
    .en      ((state == ST_GATE) || (state == ST_HOLD)),
    .ms_tick (ms_tick)
  );

  // Range decision; overflow outranks a leading zero digit, both saturate.
  always_comb begin
    next_range = Status_Value;
    if (!Auto) begin
      next_range = Man_Range;
    end else if (Overflow) begin
      if (Status_Value != RANGE_1MS) next_range = Status_Value + 2'd1;
    end else if (BCD3 == 4'd0) begin
      if (Status_Value != RANGE_1S) next_range = Status_Value - 2'd1;
    end
    next_over = Overflow && (!Auto || (Status_Value == RANGE_1MS));
  end

  always_ff @(posedge CP or negedge nRST) begin
    if (!nRST) begin
      state        <= ST_IDLE;
      Clear        <= 1'b0;
      En           <= 1'b0;
      Store        <= 1'b0;
      Status_Value <= RANGE_1S;
      Over_Ind     <= 1'b0;
      ms_cnt       <= '0;
      settle_cnt   <= '0;
    end else begin
      Clear <= 1'b0;
      Store <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_CLEAR;
          Clear <= 1'b1;
        end
        ST_CLEAR: begin
          state  <= ST_GATE;
          En     <= 1'b1;
          ms_cnt <= '0;
        end
        ST_GATE: begin
          if (ms_tick) begin
            if (ms_cnt == ms_terminal(Status_Value)) begin
              state      <= ST_SETTLE;
              En         <= 1'b0;
              ms_cnt     <= '0;
              settle_cnt <= '0;
            end else begin
              ms_cnt <= ms_cnt + 10'd1;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_STORE;
            Store <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        ST_STORE: begin
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          Status_Value <= next_range;
          Over_Ind     <= next_over;
          ms_cnt       <= '0;
          if (next_range != Status_Value) begin
            state <= ST_CLEAR;
            Clear <= 1'b1;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (ms_tick) begin
            if (ms_cnt == HOLD_TERM) begin
              state <= ST_CLEAR;
              Clear <= 1'b1;
            end else begin
              ms_cnt <= ms_cnt + 10'd1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          En    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Self-checking bench for freq_gate_ctrl: directed range scenarios plus
// randomized measurements compared against a measurement-level model.
module tb_freq_gate_ctrl;

  localparam int unsigned TICKS  = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned HOLD   = 1;
  localparam int          LIMIT  = 20000;

  logic       CP = 1'b0;
  logic       nRST = 1'b0;
  logic       Auto = 1'b0;
  logic [1:0] Man_Range = 2'd0;
  logic       Overflow = 1'b0;
  logic [3:0] BCD3 = 4'd0;
  logic       Clear, En, Store, Over_Ind;
  logic [1:0] Status_Value;

  int n_checks = 0;
  int n_errors = 0;
  int r_model  = 0;

  freq_gate_ctrl #(
    .TICKS_1MS  (TICKS),
    .SETTLE_CYC (SETTLE),
    .HOLD_MS    (HOLD)
  ) dut (
    .CP           (CP),
    .nRST         (nRST),
    .Auto         (Auto),
    .Man_Range    (Man_Range),
    .Overflow     (Overflow),
    .BCD3         (BCD3),
    .Clear        (Clear),
    .En           (En),
    .Store        (Store),
    .Status_Value (Status_Value),
    .Over_Ind     (Over_Ind)
  );

  always #5 CP = ~CP;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  // Gate length in cycles: TICKS ms quanta times 10^(3-range) ms.
  function automatic int gate_len(input int r);
    int n = TICKS;
    for (int i = 0; i < 3 - r; i++) n *= 10;
    return n;
  endfunction

  function automatic int model_next(input int r, input bit a, input int m,
                                    input bit ov, input int bcd);
    if (!a) return m;
    if (ov) return (r + 1 > 3) ? 3 : r + 1;
    if (bcd == 0) return (r - 1 < 0) ? 0 : r - 1;
    return r;
  endfunction

  // Entered on a sample where Clear is high; returns on the next Clear.
  task automatic measure(input bit a, input int m, input bit ov,
                         input int bcd, input int early_m);
    int n;
    int r_next;
    bit exp_over;
    logic [1:0] m2;
    logic [1:0] em2;
    m2  = 2'(m);
    em2 = 2'(early_m);
    check_eq("clear_status", int'(Status_Value), r_model);
    Auto      = a;
    Man_Range = em2;
    Overflow  = 1'($urandom);
    BCD3      = 4'($urandom_range(0, 15));
    tick();
    check_eq("clear_width", int'(Clear), 0);
    n = 0;
    while (En && n < LIMIT) begin
      n++;
      if (n == 2) Man_Range = m2;
      tick();
    end
    Man_Range = m2;
    check_eq("gate_len", n, gate_len(r_model));
    check_eq("gate_status", int'(Status_Value), r_model);
    n = 0;
    while (!Store && n < LIMIT) begin
      n++;
      tick();
    end
    check_eq("store_delay", n + 1, SETTLE + 1);
    Overflow = ov;
    BCD3     = 4'(bcd);
    tick();
    check_eq("store_width", int'(Store), 0);
    r_next   = model_next(r_model, a, m, ov, bcd);
    exp_over = ov && (!a || r_model == 3);
    tick();
    check_eq("eval_range", int'(Status_Value), r_next);
    check_eq("over_ind", int'(Over_Ind), int'(exp_over));
    if (r_next != r_model) begin
      check_eq("clear_no_hold", int'(Clear), 1);
    end else begin
      n = 0;
      while (!Clear && n < LIMIT) begin
        n++;
        tick();
      end
      check_eq("hold_len", n, HOLD * TICKS);
    end
    r_model = r_next;
  endtask

  initial begin
    int a, m, ovr, bcd, em;
    bit saw_store;

    #2;
    check_eq("rst_clear", int'(Clear), 0);
    check_eq("rst_en", int'(En), 0);
    check_eq("rst_store", int'(Store), 0);
    check_eq("rst_status", int'(Status_Value), 0);
    check_eq("rst_over", int'(Over_Ind), 0);

    @(posedge CP);
    #1 nRST = 1'b1;
    tick();
    check_eq("clear_after_idle", int'(Clear), 1);

    // Manual range 3 steady state with hold.
    measure(0, 3, 0, 5, 3);
    measure(0, 3, 0, 5, 3);
    measure(0, 3, 0, 5, 3);
    // Auto overflow stepping up and saturating at range 3.
    measure(0, 2, 0, 5, 2);
    measure(1, 2, 1, 5, 2);
    measure(1, 2, 1, 5, 2);
    // Auto leading-zero stepping down and saturating at range 0.
    measure(0, 1, 0, 5, 1);
    measure(1, 1, 0, 0, 1);
    measure(1, 1, 0, 0, 1);
    // Overflow wins over a zero digit.
    measure(0, 1, 0, 5, 1);
    measure(1, 1, 1, 0, 1);
    // Manual range changed mid-gate takes effect only at EVAL.
    measure(0, 3, 0, 5, 0);

    for (int i = 0; i < 20; i++) begin
      a   = $urandom_range(0, 1);
      m   = $urandom_range(1, 3);
      ovr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      bcd = $urandom_range(0, 9);
      em  = $urandom_range(0, 3);
      if (a == 1 && r_model == 1 && ovr == 0 && bcd == 0) bcd = 1;
      measure(a[0], m, ovr[0], bcd, em);
    end

    // Reset in the middle of a gate.
    tick();
    tick();
    check_eq("gate_before_rst", int'(En), 1);
    nRST = 1'b0;
    #1;
    check_eq("rst_async_en", int'(En), 0);
    check_eq("rst_async_status", int'(Status_Value), 0);
    check_eq("rst_async_clear", int'(Clear), 0);
    saw_store = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (Store) saw_store = 1'b1;
    end
    nRST = 1'b1;
    tick();
    check_eq("clear_after_release", int'(Clear), 1);
    check_eq("status_after_release", int'(Status_Value), 0);
    check_eq("en_after_release", int'(En), 0);
    tick();
    if (Store) saw_store = 1'b1;
    check_eq("en_after_clear", int'(En), 1);
    check_eq("no_store_after_rst", int'(saw_store), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
